// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the credit-based FIFO write arbiter.
package fifo_arb_pkg;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int REQ_IDX_W      = $clog2(DEF_NUM_REQ);
  localparam int CREDIT_W       = $clog2(DEF_FIFO_DEPTH) + 1;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: search starts just after last_grant.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  int               sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = 0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(last_grant) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (en && any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Credit-based round-robin arbiter feeding one FIFO write port from a register stage.
// Optional packet locking is enabled with `define ARB_PKT_LOCK_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef ARB_PKT_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_last,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_rd_en,
  input  logic                          fifo_empty,
  output logic [IDX_W-1:0]              grant_id,
  output logic [CW-1:0]                 credit_cnt
);
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      gid_q, gid_d, last_q, last_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic [NUM_REQ-1:0]    pick_req, gnt;
  logic [IDX_W-1:0]      win;
  logic                  any, can_grant, accept, read_fire;

`ifdef ARB_PKT_LOCK_EN
  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  // While a packet is open only its owner is visible to the picker.
  always_comb begin
    pick_req = req_valid;
    if (state_q == ARB_LOCKED) pick_req = req_valid & (NUM_REQ'(1) << owner_q);
  end
`else
  assign pick_req = req_valid;
`endif

  assign can_grant = (credit_q != '0) && !RST;
  assign read_fire = fifo_rd_en & ~fifo_empty;
  assign accept    = any & can_grant;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (pick_req),
    .last_grant(last_q),
    .en        (can_grant),
    .gnt       (gnt),
    .idx       (win),
    .any       (any)
  );

  always_comb begin
    wr_en_d  = accept;
    data_d   = data_q;
    gid_d    = gid_q;
    last_d   = last_q;
    credit_d = credit_q;
    if (accept) begin
      data_d = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
      gid_d  = win;
      last_d = win;
    end
    // Saturate on an (illegal) read with all credits already free.
    case ({accept, read_fire})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   if (credit_q != CW'(FIFO_DEPTH)) credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
`ifdef ARB_PKT_LOCK_EN
    state_d = state_q;
    owner_d = owner_q;
    if (accept) begin
      if (state_q == ARB_IDLE && !req_last[win]) begin
        state_d = ARB_LOCKED;
        owner_d = win;
      end else if (state_q == ARB_LOCKED && req_last[owner_q]) begin
        state_d = ARB_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_en_q  <= 1'b0;
      data_q   <= '0;
      gid_q    <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      credit_q <= CW'(FIFO_DEPTH);
`ifdef ARB_PKT_LOCK_EN
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
`endif
    end else begin
      wr_en_q  <= wr_en_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      credit_q <= credit_d;
`ifdef ARB_PKT_LOCK_EN
      state_q  <= state_d;
      owner_q  <= owner_d;
`endif
    end
  end

  assign req_ready    = gnt;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign grant_id     = gid_q;
  assign credit_cnt   = credit_q;

  credit_overflow_a: assert property (@(posedge CLK) disable iff (RST)
    !(read_fire && credit_q == CW'(FIFO_DEPTH)));
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Credit-based round-robin write arbiter that shares one synchronous FIFO (write port: data_in/wr_en; read side observed via rd_en/empty) among NUM_REQ producers.
- Accepts at most one beat per cycle from producers over a valid/ready handshake.
- Drives the FIFO write port from a registered output stage.
- Tracks free FIFO slots with its own credit counter, so in-flight writes never overflow the FIFO.
- Sits between producer blocks and the FIFO; both share CLK/RST.

Parameters:
NUM_REQ, 4, number of producers (>=2)
DATA_WIDTH, 8, beat width; equals the FIFO data width
FIFO_DEPTH, 16, depth of the attached FIFO; initial credit count (power of 2)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-producer beat valid
req_data  input  NUM_REQ*DATA_WIDTH  producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot-or-zero grant; beat transfers when valid&ready
fifo_wr_en  output  1  FIFO write strobe, registered
fifo_data_in  output  DATA_WIDTH  FIFO write data, registered
fifo_rd_en  input  1  FIFO read strobe (observed)
fifo_empty  input  1  FIFO empty flag (observed)
grant_id  output  $clog2(NUM_REQ)  source index of the beat currently on fifo_data_in
credit_cnt  output  $clog2(FIFO_DEPTH)+1  free FIFO slots, including in-flight writes

Behaviour:
- Reset (RST=1 at a clock edge), all synchronous:
  - fifo_wr_en=0, fifo_data_in=0, grant_id=0, credit_cnt=FIFO_DEPTH, last_grant=NUM_REQ-1 (so producer 0 has first priority).
  - req_ready forced to 0 while RST=1.
- Reset mid-operation discards any staged beat. The FIFO must be reset in the same cycle, so credits and FIFO state stay consistent.
- Arbitration (combinational):
  - Search order: last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Winner = first index with req_valid=1.
  - req_ready[winner]=1 only if credit_cnt!=0; all other ready bits are 0.
  - If no valid request or credit_cnt==0, req_ready=0.
- Handshake: ready may depend on valid; producers must not gate valid on ready. Once asserted, valid and data are held until accepted.
- On accept (valid&ready at edge), next cycle:
  - fifo_wr_en=1, fifo_data_in=req_data[winner], grant_id=winner.
  - last_grant updates to winner.
  - Latency: accept edge to FIFO write is 1 cycle.
- No accept: fifo_wr_en=0; fifo_data_in and grant_id hold their values.
- Credits:
  - read_fire = fifo_rd_en & ~fifo_empty.
  - credit_cnt_next = credit_cnt - accept + read_fire. Simultaneous accept and read leaves the count unchanged.
  - No same-cycle bypass: a read's credit is usable the following cycle.
- Boundaries:
  - credit_cnt==0: no grant, even if a read fires this cycle.
  - credit_cnt==FIFO_DEPTH with read_fire=1 is illegal; flag with an assertion, and saturate so the count does not wrap.
  - The FIFO's full flag is never consulted; credits guarantee fifo_wr_en is never asserted into a full FIFO.
  - Pointer wrap: last_grant = NUM_REQ-1 wraps to search start 0.
- Fairness: with all producers valid and credits available, grants rotate 0,1,...,NUM_REQ-1 back-to-back, one per cycle.

Optional Feature:
ARB_PKT_LOCK_EN
- With the macro, adds input req_last (NUM_REQ bits) and a 2-state FSM:
  - IDLE: normal round-robin. An accept with req_last[w]=0 moves to LOCKED(owner=w).
  - LOCKED: only the owner may be granted; other valid requesters wait. An accepted beat with req_last[owner]=1 returns to IDLE.
  - Credit stalls keep the lock.
  - Reset returns to IDLE.
- Without the macro: no req_last port and no FSM. Each beat is arbitrated independently.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_LOCKED}
  - localparams REQ_IDX_W = $clog2(NUM_REQ) and CREDIT_W = $clog2(FIFO_DEPTH)+1
- One sub-module, rr_pick: purely combinational rotating-priority picker.
  - Inputs: request vector, last_grant, enable.
  - Outputs: one-hot grant, index, any.
  - Top level holds all registers, credits and the FSM.

Test Plan:
All scenarios use NUM_REQ=4, DATA_WIDTH=8, FIFO_DEPTH=16.
- Reset then single producer: req_valid=0b0100, data 0xA5 -> req_ready=0b0100; next cycle fifo_wr_en=1, fifo_data_in=0xA5, grant_id=2; credit_cnt 16->15.
- All four valid continuously, no reads -> grants 0,1,2,3,0,1,2,3,... one per cycle; after 16 accepts credit_cnt=0, req_ready=0, the FIFO reaches full, no write while full.
- At credit_cnt=0, pulse fifo_rd_en (fifo_empty=0) -> credit_cnt=1 next cycle, exactly one more grant, then stall again.
- At credit_cnt=8: accept and read_fire in the same cycle -> credit_cnt stays 8. Continuous 1:1 traffic over 100 cycles -> FIFO output sequence equals the arbitrated input sequence.
- RST asserted while fifo_wr_en=1 and credit_cnt=5 -> next cycle fifo_wr_en=0, credit_cnt=16, grant_id=0; first grant after reset goes to producer 0.
- ARB_PKT_LOCK_EN: producer 1 sends a 3-beat packet (last on beat 3) while producer 2 is valid -> beats 1,1,1 are written before any producer-2 beat.
